// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 serial receiver (LSB first, idle high) feeding a
// first-word-fall-through byte FIFO, with sticky framing/overrun flags.
module uart_rx_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic                        rx_i,
    input  logic                        rx_en_i,
    input  logic [DIV_W-1:0]            clk_div_i,
    input  logic                        rd_en_i,
    input  logic                        clr_err_i,
    output logic [7:0]                  rd_data_o,
    output logic                        empty_o,
    output logic                        full_o,
    output logic [$clog2(FIFO_DEPTH):0] count_o,
    output logic                        busy_o,
    output logic                        frame_err_o,
    output logic                        overrun_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(4);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;

    // line synchronizer / edge detect
    logic             sync_a, sync_b, prev_hi;
    logic [1:0]       warm;
    logic             rx, fall;

    // receiver
    state_t           state;
    logic [DIV_W-1:0] div, cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             bit_tick, push, frame_evt;

    // fifo
    logic [7:0]       mem [0:FIFO_DEPTH-1];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             pop, wr, overrun_evt;

    assign rx   = sync_b;
    assign fall = prev_hi & ~rx;

    // Two-flop synchronizer; prev_hi only records highs that really came from
    // the line, so a line held low through reset cannot look like a falling edge.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sync_a  <= 1'b1;
            sync_b  <= 1'b1;
            warm    <= 2'd0;
            prev_hi <= 1'b0;
        end else begin
            sync_a  <= rx_i;
            sync_b  <= sync_a;
            if (warm != 2'd2) warm <= warm + 2'd1;
            prev_hi <= (warm == 2'd2) & sync_b;
        end
    end

    assign bit_tick  = (cnt == div - ONE);
    // Stop-bit outcome acts on the FIFO at the sampling edge itself.
    assign push      = rx_en_i && (state == STOP) && bit_tick && rx;
    assign frame_evt = rx_en_i && (state == STOP) && bit_tick && !rx;

    // Receive FSM: start qualification at mid-bit, then one sample per bit period.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state   <= IDLE;
            busy_o  <= 1'b0;
            cnt     <= '0;
            div     <= MIN_DIV;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
        end else if (!rx_en_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fall) begin
                        state  <= START;
                        busy_o <= 1'b1;
                        cnt    <= '0;
                        div    <= (clk_div_i < MIN_DIV) ? MIN_DIV : clk_div_i;
                    end
                end
                START: begin
                    if (cnt == (div >> 1) - ONE) begin
                        cnt     <= '0;
                        bit_idx <= 3'd0;
                        if (rx) begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end else begin
                            state  <= DATA;
                        end
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        cnt     <= '0;
                        shreg   <= {rx, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        cnt <= '0;
                        if (rx) begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end else begin
                            state  <= WAIT_HI;
                        end
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                WAIT_HI: begin
                    if (rx) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    assign empty_o     = (count == '0);
    assign full_o      = (count == CW'(FIFO_DEPTH));
    assign count_o     = count;
    assign pop         = rd_en_i && !empty_o;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign wr          = push && (!full_o || pop);
    assign overrun_evt = push && full_o && !pop;
    assign rd_data_o   = empty_o ? 8'h00 : mem[rd_ptr];

    // Storage array, no reset; empty_o gates what reaches rd_data_o.
    always_ff @(posedge wb_clk_i) begin
        if (wr) mem[wr_ptr] <= shreg;
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({wr, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags; a new event in the clearing cycle keeps the flag set.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            frame_err_o <= frame_evt   | (frame_err_o & ~clr_err_i);
            overrun_o   <= overrun_evt | (overrun_o   & ~clr_err_i);
        end
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter: FIFO_DEPTH, default 8, number of received-byte entries (power of two, 2..16).
REQ-002 Parameter: DIV_W, default 16, width of the bit-period divisor.
REQ-003 wb_clk_i  in  1  sole clock; all state is updated on its rising edge.
REQ-004 wb_rst_i  in  1  asynchronous, active-high reset.
REQ-005 rx_i  in  1  serial line (8N1, LSB first, idle high), asynchronous to wb_clk_i.
REQ-006 rx_en_i  in  1  receiver enable.
REQ-007 clk_div_i  in  DIV_W  clocks per bit.
REQ-008 rd_en_i  in  1  pop request.
REQ-009 clr_err_i  in  1  clears the sticky error flags.
REQ-010 rd_data_o  out  8  head-of-FIFO byte (first-word-fall-through).
REQ-011 empty_o / full_o  out  1 each  FIFO status.
REQ-012 count_o  out  $clog2(FIFO_DEPTH)+1  number of stored bytes.
REQ-013 busy_o  out  1  high whenever the FSM is not in IDLE.
REQ-014 frame_err_o / overrun_o  out  1 each  sticky error flags.

Function
REQ-015 rx_i SHALL pass through a 2-flop synchronizer; all references to rx below mean the synchronized value.
REQ-016 The FSM SHALL have states IDLE, START, DATA, STOP and WAIT_HI.
REQ-017 At a falling edge of rx (previous synchronized sample 1, current 0), IDLE SHALL go to START and latch div = max(clk_div_i, 4).
  - A change to clk_div_i mid-frame has no effect on that frame.
REQ-018 START: after div/2 (integer) cycles, rx is sampled.
  - rx = 0: go to DATA.
  - rx = 1: treat as a false start and return to IDLE; no error flagged.
REQ-019 DATA: every div cycles one bit is sampled into a shift register, LSB first. After 8 bits, go to STOP.
REQ-020 STOP: after div cycles, rx is sampled.
  - rx = 1: push the byte and return to IDLE.
  - rx = 0: set frame_err_o, discard the byte, go to WAIT_HI.
REQ-021 WAIT_HI SHALL return to IDLE on the first cycle rx = 1.
REQ-022 A pushed byte SHALL be visible at the outputs (empty_o = 0, rd_data_o valid) on the cycle after the stop-bit sample.
REQ-023 A push while full_o = 1 and no pop in that cycle: discard the byte, set overrun_o, leave FIFO contents unchanged.
REQ-024 A pop happens when rd_en_i = 1 and empty_o = 0.
  - rd_en_i while empty_o = 1 is ignored: no pointer or count change, no error.
REQ-025 A simultaneous push and pop SHALL both take effect; count_o is unchanged, and no overrun occurs even when full.
REQ-026 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
  - full_o = (count_o == FIFO_DEPTH); empty_o = (count_o == 0).
REQ-027 rd_data_o SHALL always show the entry at the read pointer; its value is don't-care when empty_o = 1.
REQ-028 rx_en_i = 0 SHALL force the FSM to IDLE on the next edge, abandoning any partial frame.
  - FIFO contents and flags are retained.
  - Reads continue to work.
REQ-029 clr_err_i = 1 SHALL clear both sticky flags on the next edge.
  - If an error event occurs in that same cycle, set wins.

Reset
REQ-030 While wb_rst_i = 1, all of the following SHALL hold:
  - FSM = IDLE; both synchronizer flops = 1.
  - Pointers and count_o = 0; empty_o = 1, full_o = 0, busy_o = 0.
  - frame_err_o = 0, overrun_o = 0, rd_data_o = 8'h00.
REQ-031 Reset asserted mid-frame or mid-read SHALL discard the partial byte and all FIFO contents immediately, with no push occurring.
REQ-032 After reset deasserts, a line already low SHALL NOT start a frame until rx has been seen high and then falls.

Verification
REQ-033 Normal frame: clk_div_i = 16, send 8'hA5 -> empty_o falls one cycle after the stop sample, rd_data_o = 8'hA5, count_o = 1.
REQ-034 Fill and overrun: FIFO_DEPTH = 8, send 9 bytes 8'h01..8'h09 with no reads.
  - full_o = 1 after byte 8, overrun_o = 1 after byte 9.
  - The reads then return 8'h01..8'h08 in order.
REQ-035 Framing error: send 8'h3C with the stop bit held 0 for 2 bit times.
  - frame_err_o = 1, count_o = 0, busy_o stays high until the line returns high.
  - A following 8'h5A is received correctly.
REQ-036 False start: 0 pulse of 5 cycles at clk_div_i = 16 -> FSM returns to IDLE, no push, no flag.
REQ-037 Simultaneous push/pop at full: FIFO full, assert rd_en_i on the push cycle -> count_o stays 8, overrun_o = 0, order preserved.
REQ-038 Reset/enable mid-frame:
  - Assert wb_rst_i during bit 4 of 8'hFF -> count_o = 0, no byte pushed.
  - Repeat with rx_en_i dropped instead of reset -> same result, earlier FIFO contents kept.
